// File: rtl/fifo_push_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fifo_arb_pkg
// Shared types for the FIFO push-port arbiter.
//   arb_state_e : arbiter state (IDLE = free arbitration, LOCKED = owner holds
//                 the push port until its packet ends or the burst cap hits)
//   STAT_WIDTH  : width of the optional per-requester accepted-beat counters
// ---------------------------------------------------------------------------
package fifo_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int STAT_WIDTH = 16;

endpackage : fifo_arb_pkg

// File: rtl/fifo_push_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational rotate-priority picker: returns the first set bit of `req`
// found by searching upward from `start`, wrapping modulo N.
// Ports:
//   req   [N]      : request vector
//   start [IW]     : index with highest priority this cycle (must be < N)
//   found          : at least one request is set
//   idx   [IW]     : winning index (0 when nothing is found)
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] cand;

  // NOTE: every variable written here gets a default before any branch, so
  // no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      cand = IW'((int'(start) + i) % N);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule : rr_pick

// File: rtl/fifo_push_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_push_arbiter
// Shares the push port of one synchronous FIFO among NUM_REQ valid/ready
// producers. Round-robin between packets; a winner keeps the port until it
// sends `last` or has pushed MAX_BURST beats. Grant, ready and data are
// purely combinational (zero-latency accept, no data register).
//
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   req_valid/last [N]    : producer has a beat / beat ends a packet
//   req_data [N][DW]      : producer beat data
//   req_ready [N]         : beat accepted this cycle (one-hot or zero)
//   fifo_full             : FIFO full flag
//   fifo_push             : FIFO push strobe
//   fifo_data_in [DW]     : FIFO write data (zero when not pushing)
//   locked                : arbiter is holding a grant for owner_idx
//   owner_idx [IW]        : current or most recent grant holder
//   grant_count [N][16]   : saturating accepted-beat counters; present only
//                           when FIFO_PUSH_ARB_STATS_EN is defined
// ---------------------------------------------------------------------------
module fifo_push_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int MAX_BURST  = 4,
  localparam int IW         = $clog2(NUM_REQ),
  localparam int BW         = $clog2(MAX_BURST + 1)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_data,
  input  logic [NUM_REQ-1:0]                  req_last,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic                                fifo_full,
  output logic                                fifo_push,
  output logic [DATA_WIDTH-1:0]               fifo_data_in,
  output logic                                locked,
  output logic [IW-1:0]                       owner_idx
`ifdef FIFO_PUSH_ARB_STATS_EN
  ,
  output logic [NUM_REQ-1:0][STAT_WIDTH-1:0]  grant_count
`endif
);

  localparam bit SINGLE_BEAT = (MAX_BURST == 1);

  arb_state_e    state, state_nxt;
  logic [IW-1:0] rr_ptr, rr_nxt, owner_nxt;
  logic [BW-1:0] beat_cnt, beat_nxt;
  logic [IW-1:0] pick_idx, sel;
  logic          pick_found, sel_valid, burst_end;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
    return (i == IW'(NUM_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req   (req_valid),
    .start (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign locked    = (state == LOCKED);
  // The beat being accepted now is the MAX_BURST-th of this grant.
  assign burst_end = ((beat_cnt + 1'b1) == BW'(MAX_BURST));

  always_comb begin
    // While locked only the owner is eligible, even if it is idle.
    sel       = locked ? owner_idx : pick_idx;
    sel_valid = locked ? req_valid[owner_idx] : pick_found;
    // rst gates the push so outputs read as idle for the whole reset pulse.
    fifo_push = sel_valid && !fifo_full && !rst;

    req_ready    = '0;
    fifo_data_in = '0;
    state_nxt    = state;
    rr_nxt       = rr_ptr;
    owner_nxt    = owner_idx;
    beat_nxt     = beat_cnt;

    // Nothing moves unless a beat actually transfers; a full FIFO therefore
    // freezes the lock, including on what would be the final beat.
    if (fifo_push) begin
      req_ready    = NUM_REQ'(1) << sel;
      fifo_data_in = req_data[sel];
      unique case (state)
        IDLE: begin
          owner_nxt = sel;
          if (req_last[sel] || SINGLE_BEAT) begin
            rr_nxt = wrap_inc(sel);
          end else begin
            state_nxt = LOCKED;
            beat_nxt  = BW'(1);
          end
        end
        LOCKED: begin
          if (req_last[sel] || burst_end) begin
            state_nxt = IDLE;
            rr_nxt    = wrap_inc(sel);
            beat_nxt  = '0;
          end else begin
            beat_nxt = beat_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner_idx <= '0;
      beat_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_nxt;
      owner_idx <= owner_nxt;
      beat_cnt  <= beat_nxt;
    end
  end

`ifdef FIFO_PUSH_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_count <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i] && grant_count[i] != '1) begin
          grant_count[i] <= grant_count[i] + 1'b1;
        end
      end
    end
  end
`endif

endmodule : fifo_push_arbiter

// File: tb/tb_fifo_push_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_push_arbiter
// Scoreboard bench: the driver applies one cycle of stimulus, predicts the
// transfer from a transaction-level model of the arbitration rules and queues
// it; a monitor on the falling edge pops and compares every push it sees.
// Directed scenarios are followed by a randomized phase. Build with
// FIFO_PUSH_ARB_STATS_EN to also exercise the grant counters.
// ---------------------------------------------------------------------------
module tb_fifo_push_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0]         req_valid, req_last, req_ready;
  logic [N-1:0][DW-1:0] req_data;
  logic                 fifo_full, fifo_push, locked;
  logic [DW-1:0]        fifo_data_in;
  logic [1:0]           owner_idx;
`ifdef FIFO_PUSH_ARB_STATS_EN
  logic [N-1:0][15:0]   grant_count;
`endif

  always #5 clk = ~clk;

  fifo_push_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_push    (fifo_push),
    .fifo_data_in (fifo_data_in),
    .locked       (locked),
    .owner_idx    (owner_idx)
`ifdef FIFO_PUSH_ARB_STATS_EN
    ,
    .grant_count  (grant_count)
`endif
  );

  typedef struct {
    int          idx;
    logic [7:0]  data;
  } beat_t;

  beat_t      exp_q[$];
  int         got_order[$];
  int         errors = 0;
  int         checks = 0;
  int         got_total = 0;
  int         lock_cycles = 0;

  // Reference model: who holds the port, beats in this grant, next priority.
  int         m_owner = -1;
  int         m_cnt   = 0;
  int         m_ptr   = 0;
  int         m_last  = 0;
  int         m_total = 0;
  int         m_stat[N];
  logic [5:0] seq[N];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic check_order(input string name, input int want[$]);
    check({name, "_len"}, got_order.size(), want.size());
    for (int i = 0; i < want.size(); i++)
      if (i < got_order.size()) check(name, got_order[i], want[i]);
  endtask

  task automatic model_reset();
    m_owner = -1; m_cnt = 0; m_ptr = 0; m_last = 0;
    for (int i = 0; i < N; i++) m_stat[i] = 0;
  endtask

  // One clock cycle: check registered outputs, drive inputs, predict, advance.
  task automatic cycle(input logic [N-1:0] v, input logic [N-1:0] l, input logic f);
    int    w, c;
    bit    elig;
    beat_t b;
    check("locked", locked, m_owner >= 0);
    check("owner_idx", owner_idx, m_last);
    req_valid = v;
    req_last  = l;
    fifo_full = f;
    for (int i = 0; i < N; i++) req_data[i] = {i[1:0], seq[i]};
    elig = 0;
    w    = 0;
    if (m_owner >= 0) begin
      w    = m_owner;
      elig = v[w];
    end else begin
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (!elig && v[c]) begin
          elig = 1;
          w    = c;
        end
      end
    end
    if (elig && !f) begin
      b.idx  = w;
      b.data = {w[1:0], seq[w]};
      exp_q.push_back(b);
      seq[w]++;
      m_total++;
      m_stat[w]++;
      m_last = w;
      if (m_owner < 0) begin
        if (l[w] || MB == 1) m_ptr = (w + 1) % N;
        else begin
          m_owner = w;
          m_cnt   = 1;
        end
      end else begin
        m_cnt++;
        if (l[w] || m_cnt == MB) begin
          m_owner = -1;
          m_cnt   = 0;
          m_ptr   = (w + 1) % N;
        end
      end
    end
    @(posedge clk);
    #2;
  endtask

  // Monitor: compare every observed push with the oldest prediction.
  initial begin
    int    gi;
    beat_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (locked) lock_cycles++;
        if (fifo_push) begin
          gi = -1;
          for (int k = 0; k < N; k++) if (req_ready[k]) gi = k;
          got_order.push_back(gi);
          got_total++;
          check("ready_onehot", $onehot(req_ready), 1);
          check("push_while_full", fifo_full, 0);
          check("push_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("push_idx", gi, e.idx);
            check("push_data", fifo_data_in, e.data);
          end
        end else begin
          check("ready_idle", req_ready, 0);
        end
      end
    end
  end

  initial begin
    int want[$];
    for (int i = 0; i < N; i++) seq[i] = '0;
    model_reset();
    rst       = 1'b1;
    req_valid = '1;
    req_last  = '1;
    req_data  = '1;
    fifo_full = 1'b0;
    #3;
    check("rst_push", fifo_push, 0);
    check("rst_ready", req_ready, 0);
    check("rst_data", fifo_data_in, 0);
    check("rst_locked", locked, 0);
    check("rst_owner", owner_idx, 0);
    req_valid = '0;
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Round robin with single-beat packets.
    got_order.delete();
    repeat (5) cycle(4'b1111, 4'b1111, 1'b0);
    want = '{0, 1, 2, 3, 0};
    check_order("t1_order", want);

    // Requester 2 three-beat packet against a busy requester 0.
    got_order.delete();
    lock_cycles = 0;
    cycle(4'b0101, 4'b0001, 1'b0);
    cycle(4'b0101, 4'b0001, 1'b0);
    cycle(4'b0101, 4'b0101, 1'b0);
    cycle(4'b0001, 4'b0001, 1'b0);
    want = '{2, 2, 2, 0};
    check_order("t2_order", want);
    check("t2_lock_cycles", lock_cycles, 2);

    // Requester 1 without last hits the burst cap, yields to 3, resumes.
    got_order.delete();
    repeat (5) cycle(4'b1010, 4'b1000, 1'b0);
    cycle(4'b0010, 4'b0000, 1'b0);
    cycle(4'b0010, 4'b0010, 1'b0);
    want = '{1, 1, 1, 1, 3, 1, 1};
    check_order("t3_order", want);

    // Full mid-burst, and full coinciding with the final beat.
    got_order.delete();
    cycle(4'b0001, 4'b0000, 1'b0);
    repeat (3) cycle(4'b0001, 4'b0000, 1'b1);
    cycle(4'b0001, 4'b0000, 1'b0);
    cycle(4'b0001, 4'b0000, 1'b0);
    cycle(4'b0001, 4'b0000, 1'b1);
    check("t4_lock_hold", locked, 1);
    cycle(4'b0001, 4'b0000, 1'b0);
    want = '{0, 0, 0, 0};
    check_order("t4_order", want);

    // Reset in the middle of a lock held by requester 3.
    cycle(4'b1000, 4'b0000, 1'b0);
    cycle(4'b1000, 4'b0000, 1'b0);
    check("t5_locked_pre", locked, 1);
    rst = 1'b1;
    #1;
    check("t5_rst_push", fifo_push, 0);
    check("t5_rst_ready", req_ready, 0);
    check("t5_rst_data", fifo_data_in, 0);
    check("t5_rst_locked", locked, 0);
    check("t5_rst_owner", owner_idx, 0);
    model_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    got_order.delete();
    cycle(4'b1010, 4'b1010, 1'b0);
    want = '{1};
    check_order("t5_first_grant", want);

    // Randomized traffic against the model.
    repeat (3000)
      cycle(4'($urandom), 4'($urandom), $urandom_range(0, 4) == 0);
    cycle(4'b0000, 4'b0000, 1'b0);

`ifdef FIFO_PUSH_ARB_STATS_EN
    for (int i = 0; i < N; i++) check("stat_random", grant_count[i], m_stat[i]);
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (70000) cycle(4'b0001, 4'b0001, 1'b0);
    for (int i = 0; i < N; i++)
      check("stat_saturate", grant_count[i], (m_stat[i] > 65535) ? 65535 : m_stat[i]);
`endif

    check("queue_drained", exp_q.size(), 0);
    check("push_count", got_total, m_total);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_fifo_push_arbiter
